// File: rtl/ps2_host_cmd_seq.sv
// ps2_host_cmd_seq: host-to-device command sequencer for a PS/2 keyboard port.
// It accepts a command byte and runs the host-transmit protocol: clock inhibit,
// request-to-send, 8 data bits LSB first, odd parity, stop, line-ACK check, and
// 0xFA/0xFE response handling with bounded resends and an overall timeout.
// It drives the open-drain PS/2 pins and masks the receiver while transmitting.
//
// Ports:
//   CLOCK_50, RESET           system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_data   command handshake (ready only in IDLE)
//   PS2_CLK_IN, PS2_DAT_IN    raw pin levels (synchronised internally)
//   PS2_CLK_OE, PS2_DAT_OE    1 = pull the line low
//   rx_valid, rx_data         byte strobe from the existing PS/2 receiver
//   rx_inhibit                1 = receiver must drop frames (host transmitting)
//   busy, done, status        busy outside IDLE; done pulse with status
//                             (00 ok, 01 NACK, 10 timeout, 11 no line-ACK)
//
// Optional feature macro: PS2_CMD_ARG_EN adds cmd_has_arg/cmd_arg and sends the
// argument byte as a second transaction after the command is acknowledged.

module ps2_host_cmd_seq #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
`ifdef PS2_CMD_ARG_EN
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
`endif
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DAT_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DAT_OE,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_inhibit,
  output logic       busy,
  output logic       done,
  output logic [1:0] status
);

  localparam int unsigned INH_W   = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);

  localparam logic [7:0] RESP_ACK    = 8'hFA;
  localparam logic [7:0] RESP_RESEND = 8'hFE;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NACK    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_NO_LACK = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    PARITY,
    STOP,
    LACK,
    WAIT_RESP,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         clk_sync_q, clk_sync_d;
  logic [1:0]         dat_sync_q, dat_sync_d;
  logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         byte_q, byte_d;
  logic               par_q, par_d;
  logic               clk_oe_q, clk_oe_d;
  logic               dat_oe_q, dat_oe_d;
  logic               rx_inhibit_q, rx_inhibit_d;
  logic               busy_q, busy_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               done_q, done_d;
  logic [1:0]         status_q, status_d;
`ifdef PS2_CMD_ARG_EN
  logic               has_arg_q, has_arg_d;
  logic [7:0]         arg_q, arg_d;
  logic               arg_phase_q, arg_phase_d;
`endif

  logic clk_fall;
  logic timed_state;

  // Falling edge of the synchronised device clock (oldest sample high, newer low).
  assign clk_fall    = clk_sync_q[2] & ~clk_sync_q[1];
  assign timed_state = (state_q == SEND) || (state_q == PARITY) || (state_q == STOP) ||
                       (state_q == LACK) || (state_q == WAIT_RESP);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    clk_sync_d   = {clk_sync_q[1:0], PS2_CLK_IN};
    dat_sync_d   = {dat_sync_q[0], PS2_DAT_IN};
    inh_cnt_d    = inh_cnt_q;
    to_cnt_d     = to_cnt_q;
    retry_d      = retry_q;
    bit_idx_d    = bit_idx_q;
    byte_d       = byte_q;
    par_d        = par_q;
    dat_oe_d     = dat_oe_q;
    status_d     = status_q;
`ifdef PS2_CMD_ARG_EN
    has_arg_d    = has_arg_q;
    arg_d        = arg_q;
    arg_phase_d  = arg_phase_q;
`endif

    if (timed_state) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          byte_d    = cmd_data;
          par_d     = ~^cmd_data;
          retry_d   = '0;
          inh_cnt_d = '0;
          state_d   = INHIBIT;
`ifdef PS2_CMD_ARG_EN
          has_arg_d   = cmd_has_arg;
          arg_d       = cmd_arg;
          arg_phase_d = 1'b0;
`endif
        end
      end

      INHIBIT: begin
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          state_d  = RTS;
          dat_oe_d = 1'b1;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end

      // Start bit is already on the wire; release the clock and arm the timeout.
      RTS: begin
        state_d   = SEND;
        to_cnt_d  = '0;
        bit_idx_d = '0;
      end

      SEND: begin
        if (clk_fall) begin
          dat_oe_d  = ~byte_q[bit_idx_q];
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end

      PARITY: begin
        if (clk_fall) begin
          dat_oe_d = ~par_q;
          state_d  = STOP;
        end
      end

      STOP: begin
        if (clk_fall) begin
          dat_oe_d = 1'b0;
          state_d  = LACK;
        end
      end

      LACK: begin
        if (clk_fall) begin
          if (dat_sync_q[1]) begin
            status_d = ST_NO_LACK;
            state_d  = DONE;
          end else begin
            state_d = WAIT_RESP;
          end
        end
      end

      // Bytes other than ACK/RESEND are left for the user logic and ignored here.
      WAIT_RESP: begin
        if (rx_valid) begin
          if (rx_data == RESP_ACK) begin
`ifdef PS2_CMD_ARG_EN
            if (has_arg_q && !arg_phase_q) begin
              arg_phase_d = 1'b1;
              byte_d      = arg_q;
              par_d       = ~^arg_q;
              retry_d     = '0;
              inh_cnt_d   = '0;
              state_d     = INHIBIT;
            end else begin
              status_d = ST_OK;
              state_d  = DONE;
            end
`else
            status_d = ST_OK;
            state_d  = DONE;
`endif
          end else if (rx_data == RESP_RESEND) begin
            if (retry_q < RETRY_W'(MAX_RETRY)) begin
              retry_d   = retry_q + RETRY_W'(1);
              inh_cnt_d = '0;
              state_d   = INHIBIT;
            end else begin
              status_d = ST_NACK;
              state_d  = DONE;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Timeout wins over any event seen in the same cycle.
    if (timed_state && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
      status_d = ST_TIMEOUT;
      state_d  = DONE;
    end

    // Outputs are registered from the next state so they change with it.
    clk_oe_d     = (state_d == INHIBIT) || (state_d == RTS);
    rx_inhibit_d = (state_d == INHIBIT) || (state_d == RTS) || (state_d == SEND) ||
                   (state_d == PARITY) || (state_d == STOP) || (state_d == LACK);
    if (!((state_d == RTS) || (state_d == SEND) || (state_d == PARITY) || (state_d == STOP))) begin
      dat_oe_d = 1'b0;
    end
    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);
    done_d      = (state_d == DONE);
  end

  // State and output registers; reset releases both lines immediately.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      clk_sync_q   <= 3'b111;
      dat_sync_q   <= 2'b11;
      inh_cnt_q    <= '0;
      to_cnt_q     <= '0;
      retry_q      <= '0;
      bit_idx_q    <= '0;
      byte_q       <= '0;
      par_q        <= 1'b0;
      clk_oe_q     <= 1'b0;
      dat_oe_q     <= 1'b0;
      rx_inhibit_q <= 1'b0;
      busy_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
      done_q       <= 1'b0;
      status_q     <= '0;
`ifdef PS2_CMD_ARG_EN
      has_arg_q    <= 1'b0;
      arg_q        <= '0;
      arg_phase_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      inh_cnt_q    <= inh_cnt_d;
      to_cnt_q     <= to_cnt_d;
      retry_q      <= retry_d;
      bit_idx_q    <= bit_idx_d;
      byte_q       <= byte_d;
      par_q        <= par_d;
      clk_oe_q     <= clk_oe_d;
      dat_oe_q     <= dat_oe_d;
      rx_inhibit_q <= rx_inhibit_d;
      busy_q       <= busy_d;
      cmd_ready_q  <= cmd_ready_d;
      done_q       <= done_d;
      status_q     <= status_d;
`ifdef PS2_CMD_ARG_EN
      has_arg_q    <= has_arg_d;
      arg_q        <= arg_d;
      arg_phase_q  <= arg_phase_d;
`endif
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign PS2_CLK_OE = clk_oe_q;
  assign PS2_DAT_OE = dat_oe_q;
  assign rx_inhibit = rx_inhibit_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign status     = status_q;

endmodule

// File: tb/tb_ps2_host_cmd_seq.sv
// Directed bench for ps2_host_cmd_seq with a simple PS/2 device model that
// clocks frames, reads the host's data line, returns line-ACK and responses.
module tb_ps2_host_cmd_seq;

  localparam int unsigned INH  = 40;
  localparam int unsigned TO   = 2000;
  localparam int unsigned HALF = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       cmd_ready, PS2_CLK_OE, PS2_DAT_OE, rx_inhibit, busy, done;
  logic       PS2_CLK_IN, PS2_DAT_IN;
  logic [1:0] status;
`ifdef PS2_CMD_ARG_EN
  logic       cmd_has_arg = 1'b0;
  logic [7:0] cmd_arg = 8'h00;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [1:0] last_status = 2'b00;

  // Open-drain wiring: either side may pull a line low.
  assign PS2_CLK_IN = dev_clk & ~PS2_CLK_OE;
  assign PS2_DAT_IN = dev_dat & ~PS2_DAT_OE;

  always #10 clk = ~clk;

  ps2_host_cmd_seq #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY     (2)
  ) dut (
    .CLOCK_50  (clk),
    .RESET     (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
`ifdef PS2_CMD_ARG_EN
    .cmd_has_arg(cmd_has_arg),
    .cmd_arg   (cmd_arg),
`endif
    .PS2_CLK_IN(PS2_CLK_IN),
    .PS2_DAT_IN(PS2_DAT_IN),
    .PS2_CLK_OE(PS2_CLK_OE),
    .PS2_DAT_OE(PS2_DAT_OE),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_inhibit(rx_inhibit),
    .busy      (busy),
    .done      (done),
    .status    (status)
  );

  // Record every done pulse and its status.
  always @(negedge clk) begin
    if (done) begin
      done_cnt    <= done_cnt + 1;
      last_status <= status;
    end
  end

  task automatic issue_cmd(input logic [7:0] b);
    @(negedge clk);
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_resp(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit, output logic seen);
    int n;
    n = 0;
    while (done_cnt == base && n < limit) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    seen = (done_cnt != base);
  endtask

  // Device model: measures inhibit/RTS, then clocks n_clk bits, reading the
  // line on each rising edge; on clock 11 it drives ack_bit as line-ACK.
  task automatic device_frame(input int n_clk, input logic ack_bit,
                              output logic [7:0] byte_o, output logic par_o,
                              output logic start_o, output logic stop_o,
                              output int inh_o, output int rts_o, output logic ok_o);
    int n;
    byte_o = 8'h00; par_o = 1'b0; start_o = 1'b0; stop_o = 1'b0;
    inh_o = 0; rts_o = 0; ok_o = 1'b1;
    n = 0;
    while (!PS2_CLK_OE && n < int'(INH) * 4 + 200) begin
      @(negedge clk);
      n++;
    end
    if (!PS2_CLK_OE) begin
      ok_o = 1'b0;
      return;
    end
    while (PS2_CLK_OE && !PS2_DAT_OE && inh_o < int'(INH) * 4) begin
      inh_o++;
      @(negedge clk);
    end
    while (PS2_CLK_OE && PS2_DAT_OE && rts_o < 100) begin
      rts_o++;
      @(negedge clk);
    end
    start_o = PS2_DAT_OE;
    if (n_clk == 0) return;
    repeat (4) @(negedge clk);
    for (int k = 1; k <= n_clk; k++) begin
      if (k == 11) dev_dat = ack_bit;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 8) byte_o[k-1] = ~PS2_DAT_OE;
      else if (k == 9) par_o = ~PS2_DAT_OE;
      else if (k == 10) stop_o = ~PS2_DAT_OE;
      repeat (HALF) @(negedge clk);
      dev_dat = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    obs = {cmd_ready, busy, done, PS2_CLK_OE, PS2_DAT_OE, rx_inhibit, status};
    n_cmp++;
    if (obs !== 8'b1000_0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 10000000", obs);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // 0xF4 -> 0xFA, plus busy-time cmd_valid and a stray rx byte being ignored.
  task automatic test_ok();
    logic [7:0] b; logic p, s0, s1, ok, seen, stray;
    int inh, rts, base;
    issue_cmd(8'hF4);
    device_frame(11, 1'b0, b, p, s0, s1, inh, rts, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ok_inhibit_seen: got %b want 1", ok); end
    n_cmp++; if (inh != int'(INH)) begin n_bad++; $display("FAIL ok_inhibit_len: got %0d want %0d", inh, INH); end
    n_cmp++; if (rts != 1) begin n_bad++; $display("FAIL ok_rts_len: got %0d want 1", rts); end
    n_cmp++; if (s0 !== 1'b1) begin n_bad++; $display("FAIL ok_start_bit: got dat_oe %b want 1", s0); end
    n_cmp++; if (b !== 8'hF4) begin n_bad++; $display("FAIL ok_byte: got %h want f4", b); end
    n_cmp++; if (p !== 1'b0) begin n_bad++; $display("FAIL ok_parity: got %b want 0", p); end
    n_cmp++; if (s1 !== 1'b1) begin n_bad++; $display("FAIL ok_stop: got %b want 1", s1); end
    n_cmp++;
    if ({rx_inhibit, busy, cmd_ready} !== 3'b010) begin
      n_bad++; $display("FAIL ok_wait_state: got inh/busy/rdy %b want 010", {rx_inhibit, busy, cmd_ready});
    end
    base = done_cnt;
    issue_cmd(8'h00);
    send_resp(8'h55);
    repeat (5) @(negedge clk);
    n_cmp++; if (done_cnt != base) begin n_bad++; $display("FAIL ok_stray_rx: got %0d dones want 0", done_cnt - base); end
    send_resp(8'hFA);
    wait_done(base, 20, seen);
    n_cmp++;
    if (!seen || last_status !== 2'b00) begin
      n_bad++; $display("FAIL ok_done: got seen=%b status=%b want 1/00", seen, last_status);
    end
    n_cmp++;
    if ({busy, cmd_ready} !== 2'b01) begin
      n_bad++; $display("FAIL ok_idle_after: got busy/rdy %b want 01", {busy, cmd_ready});
    end
    stray = 1'b0;
    repeat (INH) begin @(negedge clk); if (PS2_CLK_OE) stray = 1'b1; end
    n_cmp++; if (stray) begin n_bad++; $display("FAIL ok_busy_cmd_dropped: got clk_oe=1 want 0"); end
  endtask

  // 0xFF answered 0xFE three times -> three frames, NACK status.
  task automatic test_nack();
    logic [7:0] b; logic p, s0, s1, ok, seen, stray;
    int inh, rts, base, frames;
    base = done_cnt;
    frames = 0;
    issue_cmd(8'hFF);
    for (int r = 0; r < 3; r++) begin
      device_frame(11, 1'b0, b, p, s0, s1, inh, rts, ok);
      if (ok) frames++;
      n_cmp++;
      if (b !== 8'hFF || p !== 1'b1) begin
        n_bad++; $display("FAIL nack_frame%0d: got %h/%b want ff/1", r, b, p);
      end
      repeat (3) @(negedge clk);
      send_resp(8'hFE);
    end
    wait_done(base, 20, seen);
    n_cmp++; if (frames != 3) begin n_bad++; $display("FAIL nack_frames: got %0d want 3", frames); end
    n_cmp++;
    if (!seen || last_status !== 2'b01) begin
      n_bad++; $display("FAIL nack_done: got seen=%b status=%b want 1/01", seen, last_status);
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL nack_busy: got %b want 0", busy); end
    stray = 1'b0;
    repeat (2 * INH) begin @(negedge clk); if (PS2_CLK_OE) stray = 1'b1; end
    n_cmp++; if (stray) begin n_bad++; $display("FAIL nack_extra_frame: got clk_oe=1 want 0"); end
  endtask

  // 0xEE with a silent device -> timeout exactly TO cycles after clock release.
  task automatic test_timeout();
    logic [7:0] b; logic p, s0, s1, ok;
    int inh, rts, n;
    issue_cmd(8'hEE);
    device_frame(0, 1'b0, b, p, s0, s1, inh, rts, ok);
    n = 0;
    while (!done && n < int'(TO) + 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++; if (n != int'(TO)) begin n_bad++; $display("FAIL to_latency: got %0d want %0d", n, TO); end
    n_cmp++;
    if ({done, status, PS2_CLK_OE, PS2_DAT_OE} !== 5'b11000) begin
      n_bad++; $display("FAIL to_done: got done/st/clk/dat %b want 11000", {done, status, PS2_CLK_OE, PS2_DAT_OE});
    end
    repeat (3) @(negedge clk);
  endtask

  // 0xF2 with data left high at the ACK clock -> status 11 without a response.
  task automatic test_no_lack();
    logic [7:0] b; logic p, s0, s1, ok;
    int inh, rts, base;
    base = done_cnt;
    issue_cmd(8'hF2);
    device_frame(11, 1'b1, b, p, s0, s1, inh, rts, ok);
    @(negedge clk);
    n_cmp++;
    if (b !== 8'hF2 || p !== 1'b0) begin
      n_bad++; $display("FAIL nolack_frame: got %h/%b want f2/0", b, p);
    end
    n_cmp++;
    if (done_cnt != base + 1 || last_status !== 2'b11 || busy !== 1'b0) begin
      n_bad++; $display("FAIL nolack_done: got dones=%0d status=%b busy=%b want 1/11/0", done_cnt - base, last_status, busy);
    end
  endtask

  // Reset asserted after bit 4 of 0xED is on the wire.
  task automatic test_reset_mid();
    logic [7:0] b; logic p, s0, s1, ok;
    int inh, rts, base;
    base = done_cnt;
    issue_cmd(8'hED);
    device_frame(5, 1'b0, b, p, s0, s1, inh, rts, ok);
    n_cmp++;
    if ({PS2_CLK_OE, PS2_DAT_OE, busy} !== 3'b011) begin
      n_bad++; $display("FAIL rstmid_bit4: got clk/dat/busy %b want 011", {PS2_CLK_OE, PS2_DAT_OE, busy});
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({PS2_CLK_OE, PS2_DAT_OE, cmd_ready, done} !== 4'b0010) begin
      n_bad++; $display("FAIL rstmid_async: got clk/dat/rdy/done %b want 0010", {PS2_CLK_OE, PS2_DAT_OE, cmd_ready, done});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (done_cnt != base || PS2_CLK_OE !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_quiet: got dones=%0d clk_oe=%b want 0/0", done_cnt - base, PS2_CLK_OE);
    end
  endtask

`ifdef PS2_CMD_ARG_EN
  // 0xED + arg 0x07, both acknowledged -> two frames, one done.
  task automatic test_arg();
    logic [7:0] b; logic p, s0, s1, ok, seen;
    int inh, rts, base;
    base = done_cnt;
    cmd_has_arg = 1'b1;
    cmd_arg     = 8'h07;
    issue_cmd(8'hED);
    cmd_has_arg = 1'b0;
    cmd_arg     = 8'h00;
    device_frame(11, 1'b0, b, p, s0, s1, inh, rts, ok);
    n_cmp++; if (b !== 8'hED || p !== 1'b1) begin n_bad++; $display("FAIL arg_frame1: got %h/%b want ed/1", b, p); end
    send_resp(8'hFA);
    device_frame(11, 1'b0, b, p, s0, s1, inh, rts, ok);
    n_cmp++; if (b !== 8'h07 || p !== 1'b0) begin n_bad++; $display("FAIL arg_frame2: got %h/%b want 07/0", b, p); end
    n_cmp++; if (done_cnt != base) begin n_bad++; $display("FAIL arg_early_done: got %0d want 0", done_cnt - base); end
    send_resp(8'hFA);
    wait_done(base, 20, seen);
    n_cmp++;
    if (done_cnt != base + 1 || last_status !== 2'b00) begin
      n_bad++; $display("FAIL arg_done: got dones=%0d status=%b want 1/00", done_cnt - base, last_status);
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_ok();
    test_nack();
    test_timeout();
    test_no_lack();
    test_reset_mid();
`ifdef PS2_CMD_ARG_EN
    test_arg();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
